// File: rtl/bus_copy_engine_pkg.sv
// Shared types and constants for the bus copy engine and its benches.
// The optional watchdog is enabled with the BUS_COPY_TIMEOUT_EN macro.
package bus_copy_engine_pkg;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WRITE,
        FINISH
    } copy_state_e;

    localparam int          DATA_W          = 32;
    localparam int          WORD_BYTES      = 4;
    localparam logic [31:0] ADDR_ALIGN_MASK = 32'hFFFF_FFFC;

    // On-chip block RAM window, used by benches to model the responder.
    localparam logic [31:0] RAM_BASE = 32'h0000_0000;
    localparam logic [31:0] RAM_MASK = 32'h0000_3FFF;

endpackage

// File: rtl/bus_copy_engine_if.sv
// rd/wr/ready memory bus between an initiator (master) and a responder (slave).
interface bus_copy_engine_if;
    import bus_copy_engine_pkg::*;

    logic [DATA_W-1:0] bus_addr;
    logic [DATA_W-1:0] bus_wdata;
    logic [DATA_W-1:0] bus_rdata;
    logic              bus_rd;
    logic              bus_wr;
    logic              bus_ready;

    modport master (
        output bus_addr, bus_wdata, bus_rd, bus_wr,
        input  bus_rdata, bus_ready
    );

    modport slave (
        input  bus_addr, bus_wdata, bus_rd, bus_wr,
        output bus_rdata, bus_ready
    );

endinterface

// File: rtl/bus_copy_engine_watchdog.sv
// Counts consecutive unacknowledged bus cycles and flags expiry; only
// instantiated when BUS_COPY_TIMEOUT_EN is defined.
module bus_watchdog #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic active,
    input  logic ready,
    output logic expired
);
    import bus_copy_engine_pkg::*;

    localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

    logic [CNT_W-1:0] wait_count;

    // Expiry lands on the TIMEOUT_CYCLES-th consecutive waiting cycle.
    assign expired = active && !ready && (wait_count == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_count <= '0;
        end else if (!active || ready || expired) begin
            wait_count <= '0;
        end else begin
            wait_count <= wait_count + 1'b1;
        end
    end

endmodule

// File: rtl/bus_copy_engine.sv
// DMA copy engine: reads a word, then writes it, for word_count words.
// Define BUS_COPY_TIMEOUT_EN to abort transfers that never see bus_ready.
module bus_copy_engine
    import bus_copy_engine_pkg::*;
#(
    parameter int COUNT_W        = 16,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [31:0]         src_addr,
    input  logic [31:0]         dst_addr,
    input  logic [COUNT_W-1:0]  word_count,
    output logic                busy,
    output logic                done,
    output logic                error,
    bus_copy_engine_if.master   bus
);

    copy_state_e        state;
    copy_state_e        next_state;
    logic [31:0]        src_cur;
    logic [31:0]        dst_cur;
    logic [COUNT_W-1:0] remaining;
    logic [31:0]        hold;
    logic               error_q;
    logic               accept;
    logic               expired;

    assign accept = (state == IDLE) && start;

`ifdef BUS_COPY_TIMEOUT_EN
    bus_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk    (clk),
        .rst_n  (rst_n),
        .active ((state == READ) || (state == WRITE)),
        .ready  (bus.bus_ready),
        .expired(expired)
    );
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign expired = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Bus outputs decode straight from state so a reset drops requests at once.
    always_comb begin
        next_state    = state;
        bus.bus_rd    = 1'b0;
        bus.bus_wr    = 1'b0;
        bus.bus_addr  = '0;
        bus.bus_wdata = '0;
        busy          = (state != IDLE);
        done          = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    next_state = (word_count == '0) ? FINISH : READ;
                end
            end
            READ: begin
                bus.bus_rd   = 1'b1;
                bus.bus_addr = src_cur;
                if (expired) begin
                    next_state = FINISH;
                end else if (bus.bus_ready) begin
                    next_state = WRITE;
                end
            end
            WRITE: begin
                bus.bus_wr    = 1'b1;
                bus.bus_addr  = dst_cur;
                bus.bus_wdata = hold;
                if (expired) begin
                    next_state = FINISH;
                end else if (bus.bus_ready) begin
                    next_state = (remaining == COUNT_W'(1)) ? FINISH : READ;
                end
            end
            FINISH: begin
                done       = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            src_cur   <= '0;
            dst_cur   <= '0;
            remaining <= '0;
            hold      <= '0;
            error_q   <= 1'b0;
        end else if (accept) begin
            src_cur   <= src_addr & ADDR_ALIGN_MASK;
            dst_cur   <= dst_addr & ADDR_ALIGN_MASK;
            remaining <= word_count;
            error_q   <= 1'b0;
        end else begin
            if ((state == READ) && bus.bus_ready) begin
                hold <= bus.bus_rdata;
            end
            if ((state == WRITE) && bus.bus_ready) begin
                src_cur   <= src_cur + 32'(WORD_BYTES);
                dst_cur   <= dst_cur + 32'(WORD_BYTES);
                remaining <= remaining - 1'b1;
            end
            if (expired) begin
                error_q <= 1'b1;
            end
        end
    end

    assign error = error_q;

endmodule

// File: tb/tb_bus_copy_engine.sv
// Self-checking bench for bus_copy_engine against a block-RAM responder model.
// Timeout scenario runs only when BUS_COPY_TIMEOUT_EN is defined.
`timescale 1ns/1ps
module tb_bus_copy_engine;
    import bus_copy_engine_pkg::*;

    localparam int COUNT_W   = 16;
    localparam int MEM_WORDS = (int'(RAM_MASK) + 1) / WORD_BYTES;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               start = 1'b0;
    logic [31:0]        src_addr = '0;
    logic [31:0]        dst_addr = '0;
    logic [COUNT_W-1:0] word_count = '0;
    logic               busy;
    logic               done;
    logic               error;

    bus_copy_engine_if bus ();

    bus_copy_engine #(
        .COUNT_W       (COUNT_W),
        .TIMEOUT_CYCLES(255)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .src_addr  (src_addr),
        .dst_addr  (dst_addr),
        .word_count(word_count),
        .busy      (busy),
        .done      (done),
        .error     (error),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    logic [31:0] mem   [MEM_WORDS];
    logic [31:0] model [MEM_WORDS];

    function automatic logic mapped(input logic [31:0] a);
        return (a & ~RAM_MASK) == RAM_BASE;
    endfunction

    function automatic int widx(input logic [31:0] a);
        return int'((a & RAM_MASK) >> 2);
    endfunction

    // Block RAM responder: reads ack once the address has been held a cycle, writes ack at once.
    logic        prev_rd;
    logic [31:0] prev_addr;

    always_comb begin
        bus.bus_ready = 1'b0;
        bus.bus_rdata = '0;
        if (bus.bus_rd && mapped(bus.bus_addr)) begin
            bus.bus_rdata = mem[widx(bus.bus_addr)];
            bus.bus_ready = prev_rd && (prev_addr == bus.bus_addr);
        end else if (bus.bus_wr && mapped(bus.bus_addr)) begin
            bus.bus_ready = 1'b1;
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_rd   <= 1'b0;
            prev_addr <= '0;
        end else begin
            prev_rd   <= bus.bus_rd;
            prev_addr <= bus.bus_addr;
            if (bus.bus_wr && bus.bus_ready) begin
                mem[widx(bus.bus_addr)] = bus.bus_wdata;
            end
        end
    end

    // Bus monitor, sampled on the falling edge.
    int          cycle = 0;
    int          busy_cycles, done_pulses, rd_cycles, wr_cycles;
    int          overlap_cycles, misalign_cycles, hold_viol;
    int          first_rd, done_cycle;
    bit          pend_rd, pend_wr;
    logic [31:0] pend_addr, pend_wdata;
    logic [33:0] last_req;
    logic [31:0] addr_q [$];

    task automatic clearMonitor();
        busy_cycles = 0; done_pulses = 0; rd_cycles = 0; wr_cycles = 0;
        overlap_cycles = 0; misalign_cycles = 0; hold_viol = 0;
        first_rd = -1; done_cycle = -1;
        addr_q.delete();
    endtask

    always @(negedge clk) begin
        cycle++;
        if (busy) busy_cycles++;
        if (done) begin
            done_pulses++;
            done_cycle = cycle;
        end
        if (bus.bus_rd) begin
            rd_cycles++;
            if (first_rd < 0) first_rd = cycle;
        end
        if (bus.bus_wr) wr_cycles++;
        if (bus.bus_rd && bus.bus_wr) overlap_cycles++;
        if (bus.bus_addr[1:0] != 2'b00) misalign_cycles++;
        if (rst_n && !done) begin
            if (pend_rd && !(bus.bus_rd && bus.bus_addr == pend_addr)) hold_viol++;
            if (pend_wr && !(bus.bus_wr && bus.bus_addr == pend_addr && bus.bus_wdata == pend_wdata)) hold_viol++;
        end
        if ((bus.bus_rd || bus.bus_wr) && ({bus.bus_rd, bus.bus_wr, bus.bus_addr} != last_req)) begin
            addr_q.push_back(bus.bus_addr);
        end
        last_req   = {bus.bus_rd, bus.bus_wr, bus.bus_addr};
        pend_rd    = rst_n && bus.bus_rd && !bus.bus_ready;
        pend_wr    = rst_n && bus.bus_wr && !bus.bus_ready;
        pend_addr  = bus.bus_addr;
        pend_wdata = bus.bus_wdata;
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
        end
    endtask

    // Starts a copy, updates the reference memory and waits for busy to fall.
    task automatic applyStimulus(input logic [31:0] s, input logic [31:0] d, input int n,
                                 input int model_words, input bit double_start, input int bound);
        for (int i = 0; i < MEM_WORDS; i++) model[i] = mem[i];
        for (int i = 0; i < model_words; i++) begin
            model[(widx(d) + i) % MEM_WORDS] = model[(widx(s) + i) % MEM_WORDS];
        end
        clearMonitor();
        @(negedge clk);
        src_addr   = s;
        dst_addr   = d;
        word_count = COUNT_W'(n);
        start      = 1'b1;
        @(negedge clk);
        if (double_start) begin
            src_addr   = s ^ 32'h40;
            dst_addr   = d ^ 32'h100;
            word_count = COUNT_W'(n + 3);
            @(negedge clk);
        end
        start = 1'b0;
        for (int i = 0; i < bound && busy; i++) @(negedge clk);
        checkOutput("finished_in_time", 32'(busy), 32'h0);
    endtask

    task automatic checkCopy(input string tag, input int n);
        int diffs;
        diffs = 0;
        for (int i = 0; i < MEM_WORDS; i++) if (mem[i] !== model[i]) diffs++;
        checkOutput({tag, "_busy_cycles"}, 32'(busy_cycles), 32'(3 * n + 1));
        checkOutput({tag, "_done_pulses"}, 32'(done_pulses), 32'h1);
        checkOutput({tag, "_error"}, 32'(error), 32'h0);
        checkOutput({tag, "_rd_cycles"}, 32'(rd_cycles), 32'(2 * n));
        checkOutput({tag, "_wr_cycles"}, 32'(wr_cycles), 32'(n));
        checkOutput({tag, "_rd_wr_overlap"}, 32'(overlap_cycles), 32'h0);
        checkOutput({tag, "_misaligned"}, 32'(misalign_cycles), 32'h0);
        checkOutput({tag, "_req_hold"}, 32'(hold_viol), 32'h0);
        checkOutput({tag, "_mem_diff_words"}, 32'(diffs), 32'h0);
    endtask

    initial begin
        logic [31:0] old_word;
        int          wrs;
        int          n;
        logic [31:0] s;
        logic [31:0] d;

        for (int i = 0; i < MEM_WORDS; i++) mem[i] = $urandom;
        clearMonitor();

        #1;
        checkOutput("rst_busy", 32'(busy), 32'h0);
        checkOutput("rst_done", 32'(done), 32'h0);
        checkOutput("rst_error", 32'(error), 32'h0);
        checkOutput("rst_bus_rd_wr", {30'h0, bus.bus_rd, bus.bus_wr}, 32'h0);
        checkOutput("rst_bus_addr", bus.bus_addr, 32'h0);
        checkOutput("rst_bus_wdata", bus.bus_wdata, 32'h0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Four-word copy of a known pattern.
        for (int i = 0; i < 4; i++) mem[32'h40 + i] = 32'hA0 + 32'(i);
        applyStimulus(32'h100, 32'h200, 4, 4, 1'b0, 40);
        checkCopy("four_words", 4);
        for (int i = 0; i < 4; i++) checkOutput("four_words_dst", mem[32'h80 + i], 32'hA0 + 32'(i));

        // Zero-length copy.
        applyStimulus(32'h40, 32'h80, 0, 0, 1'b0, 20);
        checkCopy("zero_count", 0);

        // Unaligned addresses are truncated to word boundaries.
        applyStimulus(32'h103, 32'h207, 1, 1, 1'b0, 20);
        checkCopy("unaligned", 1);
        checkOutput("unaligned_req_count", 32'(addr_q.size()), 32'h2);
        if (addr_q.size() == 2) begin
            checkOutput("unaligned_rd_addr", addr_q[0], 32'h100);
            checkOutput("unaligned_wr_addr", addr_q[1], 32'h204);
        end

        // A second start while busy is ignored.
        applyStimulus(32'h500, 32'h600, 2, 2, 1'b1, 30);
        checkCopy("double_start", 2);

`ifdef BUS_COPY_TIMEOUT_EN
        // Unmapped source never acknowledges, so the watchdog aborts the copy.
        applyStimulus(32'h8000, 32'h200, 1, 0, 1'b0, 400);
        checkOutput("timeout_error", 32'(error), 32'h1);
        checkOutput("timeout_done_pulses", 32'(done_pulses), 32'h1);
        checkOutput("timeout_wr_cycles", 32'(wr_cycles), 32'h0);
        checkOutput("timeout_latency", 32'(done_cycle - first_rd), 32'd255);
        applyStimulus(32'h300, 32'h700, 1, 1, 1'b0, 20);
        checkCopy("after_timeout", 1);
`endif

        // Randomized copies, overlapping ranges included.
        for (int t = 0; t < 8; t++) begin
            n = int'($urandom_range(0, 8));
            s = (32'($urandom_range(0, 300)) << 2) | 32'($urandom_range(0, 3));
            d = ((32'($urandom_range(0, 300)) + ((t % 2 == 0) ? 32'h0 : 32'h3)) << 2) | 32'($urandom_range(0, 3));
            applyStimulus(s, d, n, n, 1'b0, 3 * n + 20);
            checkCopy("random", n);
        end

        // Reset asserted during the second word's write.
        old_word = mem[32'h101];
        clearMonitor();
        @(negedge clk);
        src_addr   = 32'h300;
        dst_addr   = 32'h400;
        word_count = COUNT_W'(4);
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wrs   = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.bus_wr) begin
                wrs++;
                if (wrs == 2) break;
            end
            @(negedge clk);
        end
        checkOutput("rst_mid_reached_write2", 32'(wrs), 32'h2);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("rst_mid_bus_wr", 32'(bus.bus_wr), 32'h0);
        checkOutput("rst_mid_busy", 32'(busy), 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("rst_mid_done_pulses", 32'(done_pulses), 32'h0);
        checkOutput("rst_mid_word0", mem[32'h100], mem[32'hC0]);
        checkOutput("rst_mid_word1", mem[32'h101], old_word);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
